// File: rtl/adder7_seq_ctrl.sv
// Sequential multi-operand adder: one shared WIDTH-bit adder sums NOPS streamed operands,
// chaining each stage's carry-out into the next stage's carry-in; op_ready is a pure state decode.

module adder7 (
  input  logic [6:0] a_i,
  input  logic [6:0] b_i,
  input  logic       ci_i,
  output logic [6:0] s_o,
  output logic       co_o
);
  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {7'b0, ci_i};
endmodule

module adder7_seq_ctrl #(
  parameter int WIDTH = 7,
  parameter int NOPS  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ci_i,
  input  logic             op_valid_i,
  input  logic [WIDTH-1:0] op_data_i,
  output logic             op_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o
);
  localparam int CW = $clog2(NOPS);
  // Last operand is detected before the increment, so count never needs to hold NOPS.
  localparam logic [CW-1:0] LAST = CW'(NOPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACCUM, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cr_q, cr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_co;
  logic             xfer;

  generate
    if (WIDTH == 7) begin : g_adder7
      adder7 u_add (
        .a_i  (acc_q),
        .b_i  (op_data_i),
        .ci_i (cr_q),
        .s_o  (add_sum),
        .co_o (add_co)
      );
    end else begin : g_adder_generic
      assign {add_co, add_sum} = {1'b0, acc_q} + {1'b0, op_data_i} + {{WIDTH{1'b0}}, cr_q};
    end
  endgenerate

  assign xfer = op_valid_i & op_ready_o;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    cr_d       = cr_q;
    sum_d      = sum_q;
    co_d       = co_q;
    op_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          cr_d    = ci_i;
          count_d = '0;
        end
      end
      S_LOAD: begin
        op_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (xfer) begin
          acc_d   = op_data_i;
          count_d = CW'(1);
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        op_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (xfer) begin
          acc_d   = add_sum;
          cr_d    = add_co;
          count_d = count_q + CW'(1);
          if (count_q == LAST) begin
            sum_d   = add_sum;
            co_d    = add_co;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          state_d = S_LOAD;
          cr_d    = ci_i;
          count_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      cr_q    <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      cr_q    <= cr_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign sum_o = sum_q;
  assign co_o  = co_q;

endmodule
